// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the RV32I instruction-fetch stage.
package fetch_stage_pkg;

   localparam int          XLEN_DEF = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0, x0, 0

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,   // nothing outstanding
      ST_WAIT = 2'd1,   // awaiting the response to our own request
      ST_DROP = 2'd2    // awaiting a stale response that must be thrown away
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
   parameter int XLEN = 32
) ();

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds, or inserts a bubble.
module fetch_stage_ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            bubble_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     inst_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic [31:0]     inst_o
);

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4_q;
   logic [31:0]     inst_q;

   // A bubble only clears valid and the instruction; the PC fields keep their
   // last value since nothing downstream looks at them while valid is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         pc_plus4_q <= XLEN'(4);
         inst_q     <= NOP_INST;
      end else if (bubble_i) begin
         valid_q    <= 1'b0;
         inst_q     <= NOP_INST;
      end else if (load_i) begin
         valid_q    <= 1'b1;
         pc_q       <= pc_i;
         pc_plus4_q <= pc_i + XLEN'(4);
         inst_q     <= inst_i;
      end
   end

   assign valid_o    = valid_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign inst_o     = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps one imem request in flight, buffers a response
// that lands while IF/ID is stalled, and obeys kill/redirect from later stages.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write,
   input  logic              ifid_write,
   input  logic              if_kill,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   fetch_stage_if.master     imem,
   output logic              ifid_valid,
   output logic [XLEN-1:0]   ifid_pc,
   output logic [XLEN-1:0]   ifid_pc_plus4,
   output logic [31:0]       ifid_inst
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            hold_valid_q, hold_valid_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic [31:0]     hold_inst_q, hold_inst_d;

   logic            req_now;
   logic            grant;
   logic            resp;
   logic            have_deliv;
   logic [XLEN-1:0] deliv_pc;
   logic [31:0]     deliv_inst;
   logic [XLEN-1:0] redirect_tgt;
   logic            ifid_load;
   logic            ifid_bubble;

   // A full hold buffer blocks new requests, so hold and a live response never coexist.
   assign req_now        = rst_n && (state_q == ST_REQ) && pc_write
                           && !hold_valid_q && !redirect_valid;
   assign imem.imem_req  = req_now;
   assign imem.imem_addr = pc_q;

   assign grant        = req_now && imem.imem_gnt;
   assign resp         = (state_q == ST_WAIT) && imem.imem_rvalid;
   assign have_deliv   = hold_valid_q || resp;
   assign deliv_pc     = hold_valid_q ? hold_pc_q   : req_pc_q;
   assign deliv_inst   = hold_valid_q ? hold_inst_q : imem.imem_rdata;
   assign redirect_tgt = redirect_pc & ~XLEN'(3);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      hold_valid_d = hold_valid_q;
      hold_pc_d    = hold_pc_q;
      hold_inst_d  = hold_inst_q;
      ifid_load    = 1'b0;
      ifid_bubble  = 1'b0;

      if (redirect_valid) begin
         pc_d         = redirect_tgt;
         hold_valid_d = 1'b0;
         ifid_bubble  = 1'b1;
         // An outstanding request becomes stale; if its data lands now it is simply dropped.
         if (state_q != ST_REQ) begin
            state_d = imem.imem_rvalid ? ST_REQ : ST_DROP;
         end
      end else if (if_kill && (have_deliv || (state_q == ST_WAIT))) begin
         // Rewind to the killed instruction so it is fetched again.
         pc_d         = deliv_pc;
         hold_valid_d = 1'b0;
         ifid_bubble  = ifid_write;
         if (state_q == ST_WAIT) begin
            state_d = resp ? ST_REQ : ST_DROP;
         end
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (grant) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + XLEN'(4);
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT, ST_DROP: begin
               if (imem.imem_rvalid) begin
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_REQ;
         endcase

         if (ifid_write) begin
            hold_valid_d = 1'b0;
            ifid_load    = have_deliv;
            ifid_bubble  = !have_deliv;
         end else if (resp) begin
            hold_valid_d = 1'b1;
            hold_pc_d    = req_pc_q;
            hold_inst_d  = imem.imem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         req_pc_q     <= '0;
         hold_valid_q <= 1'b0;
         hold_pc_q    <= '0;
         hold_inst_q  <= NOP_INST;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_pc_q    <= hold_pc_d;
         hold_inst_q  <= hold_inst_d;
      end
   end

   fetch_stage_ifid_reg #(
      .XLEN (XLEN)
   ) u_ifid_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ifid_load),
      .bubble_i   (ifid_bubble),
      .pc_i       (deliv_pc),
      .inst_i     (deliv_inst),
      .valid_o    (ifid_valid),
      .pc_o       (ifid_pc),
      .pc_plus4_o (ifid_pc_plus4),
      .inst_o     (ifid_inst)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench: the delivered instruction stream must follow program order
// from reset/redirect targets, with each word matching a fixed memory image.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int          XLEN    = 32;
   localparam logic [31:0] BOOT_PC = 32'h0000_0000;
   localparam int          NCYC    = 4000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write;
   logic        ifid_write;
   logic        if_kill;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
   logic [31:0] ifid_inst;

   always #5 clk = ~clk;

   fetch_stage_if #(.XLEN(XLEN)) imem_bus ();

   fetch_stage #(
      .XLEN     (XLEN),
      .RESET_PC (BOOT_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_write       (pc_write),
      .ifid_write     (ifid_write),
      .if_kill        (if_kill),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem_bus),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .ifid_inst      (ifid_inst)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int deliveries   = 0;
   bit mon_stop     = 1'b0;
   bit rst_done     = 1'b0;

   // Program-order scoreboard: upcoming addresses the stage must deliver next.
   logic [31:0] exp_q[$];
   logic [31:0] next_fetch;

   // Memory image: every address maps to a distinct-looking word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h9E37_79B9 ^ (a << 3);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %0s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(next_fetch);
         next_fetch = next_fetch + 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] target);
      exp_q.delete();
      next_fetch = target;
      refill();
   endtask

   // Stimulus + memory responder, all changes made on the falling edge.
   initial begin : driver
      bit          pend;
      bit          stale_next;
      int          lat;
      logic [31:0] pend_addr;
      logic [31:0] tgt;

      pend       = 1'b0;
      stale_next = 1'b0;
      lat        = 0;
      pend_addr  = '0;
      rst_n          = 1'b0;
      pc_write       = 1'b1;
      ifid_write     = 1'b1;
      if_kill        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_bus.imem_gnt    = 1'b1;
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
      restart(BOOT_PC);

      repeat (2) begin
         @(negedge clk);
         #1;
         check("req_in_reset", 32'(imem_bus.imem_req), 32'd0);
      end

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (!rst_done && cyc >= 1500 && pend) begin
            // Abandon the in-flight request; one stale rvalid may follow.
            rst_done   = 1'b1;
            rst_n      = 1'b0;
            pend       = 1'b0;
            stale_next = ($urandom % 2) == 0;
            redirect_valid       = 1'b0;
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_gnt    = 1'b1;
            restart(BOOT_PC);
            $display("[TB] reset asserted mid-transaction at cycle %0d", cyc);
            #1;
            check("req_in_midrun_reset", 32'(imem_bus.imem_req), 32'd0);
            continue;
         end
         rst_n          = 1'b1;
         pc_write       = ($urandom % 5) != 0;
         ifid_write     = ($urandom % 4) != 0;
         if_kill        = ($urandom % 12) == 0;
         redirect_valid = ($urandom % 20) == 0;
         if (redirect_valid) begin
            case ($urandom % 3)
               0:       tgt = $urandom;
               1:       tgt = 32'hFFFF_FFF0 | 32'($urandom % 16);
               default: tgt = 32'(($urandom % 64) * 4 + ($urandom % 4));
            endcase
            redirect_pc = tgt;
            restart(tgt & 32'hFFFF_FFFC);
         end else begin
            redirect_pc = $urandom;
         end
         refill();
         #1;
         if (redirect_valid) check("req_during_redirect", 32'(imem_bus.imem_req), 32'd0);
         if (pend)           check("req_while_outstanding", 32'(imem_bus.imem_req), 32'd0);

         if (stale_next) begin
            stale_next           = 1'b0;
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = 32'hDEAD_BEEF;
            imem_bus.imem_gnt    = 1'b0;
         end else if (pend && lat == 0) begin
            pend                 = 1'b0;
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = mem_word(pend_addr);
            imem_bus.imem_gnt    = 1'b0;
         end else begin
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_rdata  = $urandom;
            if (pend) lat--;
            imem_bus.imem_gnt = ($urandom % 3) != 0;
            if (!pend && imem_bus.imem_req && imem_bus.imem_gnt) begin
               pend      = 1'b1;
               pend_addr = imem_bus.imem_addr;
               lat       = int'($urandom % 3);
            end
         end
      end

      @(negedge clk);
      mon_stop = 1'b1;
      @(posedge clk);
      #2;
      check("midrun_reset_hit", 32'(rst_done), 32'd1);
      tests_run++;
      if (deliveries < 300) begin
         tests_failed++;
         $display("[TB] FAIL throughput: got %0d deliveries expected at least 300", deliveries);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Monitor: after each edge, compare IF/ID against the scoreboard image.
   initial begin : monitor
      bit          r, rd, w;
      bit          img_valid;
      logic [31:0] img_pc, img_p4, img_inst, e;

      img_valid = 1'b0;
      img_pc    = '0;
      img_p4    = 32'd4;
      img_inst  = NOP_INST;
      forever begin
         @(posedge clk);
         r  = rst_n;
         rd = redirect_valid;
         w  = ifid_write;
         #1;
         if (mon_stop) break;
         if (!r) begin
            check("rst_valid", 32'(ifid_valid), 32'd0);
            check("rst_pc", ifid_pc, 32'd0);
            check("rst_pc_plus4", ifid_pc_plus4, 32'd4);
            check("rst_inst", ifid_inst, NOP_INST);
            img_valid = 1'b0;
            img_inst  = NOP_INST;
         end else if (rd) begin
            check("redirect_bubble_valid", 32'(ifid_valid), 32'd0);
            check("redirect_bubble_inst", ifid_inst, NOP_INST);
            img_valid = 1'b0;
            img_inst  = NOP_INST;
         end else if (!w) begin
            check("stall_valid", 32'(ifid_valid), 32'(img_valid));
            check("stall_inst", ifid_inst, img_inst);
            if (img_valid) begin
               check("stall_pc", ifid_pc, img_pc);
               check("stall_pc_plus4", ifid_pc_plus4, img_p4);
            end
         end else if (ifid_valid) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_delivery: got pc %h with no expected entry", ifid_pc);
            end else begin
               e = exp_q.pop_front();
               check("deliver_pc", ifid_pc, e);
               check("deliver_pc_plus4", ifid_pc_plus4, e + 32'd4);
               check("deliver_inst", ifid_inst, mem_word(e));
               img_valid = 1'b1;
               img_pc    = e;
               img_p4    = e + 32'd4;
               img_inst  = mem_word(e);
               deliveries++;
               $display("[TB] deliver pc=%h inst=%h", ifid_pc, ifid_inst);
            end
         end else begin
            check("bubble_inst", ifid_inst, NOP_INST);
            img_valid = 1'b0;
            img_inst  = NOP_INST;
         end
      end
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the RV32I 5-stage pipeline: owns the PC, issues instruction-memory requests and drives the IF/ID pipeline register consumed by decode and the hazard detection unit.
- Obeys hazard-unit controls (pc_write, ifid_write, if_kill) and EX-stage branch/jump redirects.
- One outstanding imem request max; single-entry hold buffer absorbs a response arriving while IF/ID is stalled.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
XLEN, 32, address/data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
pc_write  in  1  0 = stall PC, suppress new requests
ifid_write  in  1  0 = hold IF/ID register
if_kill  in  1  discard instruction delivered this cycle, refetch it
redirect_valid  in  1  EX-stage taken branch/jump
redirect_pc  in  XLEN  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid, >=1 cycle after gnt, in order
imem_rdata  in  32  instruction word
ifid_valid  out  1  IF/ID holds a real instruction
ifid_pc  out  XLEN  PC of IF/ID instruction
ifid_pc_plus4  out  XLEN  ifid_pc + 4
ifid_inst  out  32  instruction (NOP when invalid)

Behaviour:
- Clock clk; reset synchronous, active-low (rst_n); all state updates on rising edge.
- Reset: pc=RESET_PC, state=REQ, hold empty, imem_req=0 in reset cycle, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=4, ifid_inst=NOP (32'h0000_0013). Reset mid-transaction abandons it; a late rvalid after reset is ignored unless state=WAIT.
- Registers: pc (next fetch addr), req_pc (addr in flight), hold_valid/hold_pc/hold_inst.
- States: REQ (none outstanding), WAIT (awaiting own response), DROP (awaiting stale response to discard).
- REQ: imem_req = pc_write & ~hold_valid & ~redirect_valid; imem_addr=pc. On req&gnt: req_pc<=pc, pc<=pc+4, ->WAIT. imem_req/imem_addr stable until gnt.
- WAIT: on rvalid ->REQ; instruction {req_pc, rdata} delivered.
- Delivery: source is hold buffer if hold_valid, else WAIT response. ifid_write=1: IF/ID <= {valid=1, pc, pc+4, inst}, hold cleared. ifid_write=0: IF/ID unchanged; a WAIT response goes to hold buffer.
- ifid_write=1 with nothing to deliver: IF/ID loads bubble (valid=0, inst=NOP).
- DROP: on rvalid discard data, ->REQ; nothing delivered.
- if_kill (priority below redirect): delivered/buffered instruction discarded, hold cleared, pc<=its address (hold_pc or req_pc). If asserted in WAIT without rvalid: pc<=req_pc, ->DROP. In REQ with no pending delivery: no effect. IF/ID follows ifid_write (bubble if 1, hold if 0).
- redirect_valid (highest priority, ignores pc_write/ifid_write): pc<={redirect_pc[XLEN-1:2],2'b00}; hold cleared; IF/ID <= bubble; WAIT without rvalid ->DROP; WAIT with rvalid: response discarded, ->REQ; DROP stays DROP.
- Arithmetic: pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
- Simultaneous rvalid+gnt impossible (one outstanding); gnt while imem_req=0 ignored.

Decomposition:
- Shared package/defines: NOP_INST 32'h0000_0013, state encoding (REQ/WAIT/DROP), XLEN default.
- One sub-module natural: ifid_reg (IF/ID pipeline register with write-enable and bubble insert). Hold buffer and FSM stay in fetch_stage.

Test Plan:
- Reset, gnt=1, 1-cycle rvalid -> first fetch 0x0; ifid_pc 0x0,0x4,0x8 on successive deliveries with matching ifid_inst; ifid_valid=0 until first rvalid.
- ifid_write=0 for 3 cycles while response for 0x8 arrives -> hold_valid=1, imem_req=0, IF/ID unchanged; on release ifid_pc=0x8 next edge, fetch resumes 0xC.
- Redirect to 0x100 while WAIT (rvalid 2 cycles later) -> DROP, stale data never appears, next imem_addr=0x100, IF/ID bubble meanwhile.
- Redirect to 0x103 -> imem_addr=0x100; redirect with pc_write=0 still updates pc.
- if_kill with rvalid for 0x10 and ifid_write=0 -> 0x10 discarded, next imem_addr=0x10, IF/ID holds.
- pc=0xFFFF_FFFC granted -> next imem_addr=0x0; rst_n low mid-WAIT -> pc=RESET_PC, ifid_valid=0 next edge.
